// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter feeding one shared unsigned multiplier
// Carry-save array multiplier plus the arbiter/output-register top.

module wallace_mul #(
  parameter int DWI = 8,
  parameter int DWO = 2 * DWI
) (
  input  logic [DWI-1:0] a,
  input  logic [DWI-1:0] b,
  output logic [DWO-1:0] p
);

  logic [DWO-1:0] sum_v;
  logic [DWO-1:0] carry_v;
  logic [DWO-1:0] pp_v;
  logic [DWO-1:0] nsum_v;

  // Partial products are folded through 3:2 compressors; one carry-propagate add at the end.
  // Carries shifted past DWO are multiples of 2^DWO and cannot affect an in-range product.
  always_comb begin
    sum_v   = '0;
    carry_v = '0;
    pp_v    = '0;
    nsum_v  = '0;
    for (int i = 0; i < DWI; i++) begin
      pp_v    = b[i] ? (DWO'(a) << i) : '0;
      nsum_v  = sum_v ^ carry_v ^ pp_v;
      carry_v = ((sum_v & carry_v) | (sum_v & pp_v) | (carry_v & pp_v)) << 1;
      sum_v   = nsum_v;
    end
    p = sum_v + carry_v;
  end

endmodule

module mul_arbiter #(
  parameter int NREQ = 4,
  parameter int DWI  = 8,
  parameter int DWO  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWI-1:0]      req_op1,
  input  logic [NREQ*DWI-1:0]      req_op2,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DWO-1:0]           rsp_data,
  input  logic                     rsp_ready
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [DWO-1:0] rsp_data_q, rsp_data_d;

  logic [IDW-1:0] win_idx;
  logic           win_found;
  logic           out_free;
  logic           xfer;
  logic [DWI-1:0] mul_a, mul_b;
  logic [DWO-1:0] mul_p;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment;
  // NREQ is a power of two, so the IDW-bit add wraps naturally.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[rr_ptr_q + IDW'(k)]) begin
        win_found = 1'b1;
        win_idx   = rr_ptr_q + IDW'(k);
      end
    end
  end

  assign out_free  = !rsp_valid_q || rsp_ready;
  assign xfer      = rst_n && en && out_free && win_found;
  assign req_ready = xfer ? ({{(NREQ-1){1'b0}}, 1'b1} << win_idx) : '0;

  assign mul_a = req_op1[win_idx*DWI +: DWI];
  assign mul_b = req_op2[win_idx*DWI +: DWI];

  wallace_mul #(.DWI(DWI), .DWO(DWO)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (xfer) begin
      rr_ptr_d    = win_idx + IDW'(1);
      rsp_valid_d = 1'b1;
      rsp_id_d    = win_idx;
      rsp_data_d  = mul_p;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - directed vector table plus corner sequences for mul_arbiter
// Fixed operands per requester; a random phase checks products against a bench scoreboard.

module tb_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_ready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mul_arbiter #(.NREQ(4), .DWI(8), .DWO(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  typedef struct {
    logic        en;
    logic [3:0]  vld;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_id;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  vec_t        tbl[17];
  exp_t        exp_q[$];
  logic [15:0] prod[4];
  logic [7:0]  ra[4];
  logic [7:0]  rb[4];
  logic        pend[4];
  int          n_xfer;

  function automatic vec_t mk(input logic e, input logic [3:0] v, input logic r,
                              input logic [3:0] er, input logic ev,
                              input logic [1:0] ei, input logic [15:0] ed);
    vec_t t;
    t.en = e; t.vld = v; t.rdy = r; t.exp_ready = er;
    t.exp_valid = ev; t.exp_id = ei; t.exp_data = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // r3..r0: op1 = 10,255,16,0 ; op2 = 20,255,16,200
    req_op1   = {8'd10, 8'd255, 8'd16, 8'd0};
    req_op2   = {8'd20, 8'd255, 8'd16, 8'd200};
    prod[0] = 16'h0000; prod[1] = 16'h0100; prod[2] = 16'hFE01; prod[3] = 16'h00C8;

    tbl[0]  = mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    tbl[1]  = mk(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hFE01);
    tbl[2]  = mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 16'hFE01);
    tbl[3]  = mk(1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h00C8);
    tbl[4]  = mk(1'b1, 4'b0111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0000);
    tbl[5]  = mk(1'b1, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0100);
    tbl[6]  = mk(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h0100);
    tbl[7]  = mk(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h0100);
    tbl[8]  = mk(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hFE01);
    tbl[9]  = mk(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd2, 16'hFE01);
    tbl[10] = mk(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd2, 16'hFE01);
    tbl[11] = mk(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd2, 16'hFE01);
    tbl[12] = mk(1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0100);
    tbl[13] = mk(1'b1, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h00C8);
    tbl[14] = mk(1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0000);
    tbl[15] = mk(1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h00C8);
    tbl[16] = mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 16'h00C8);

    rst_n = 1'b0; en = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
    #12;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_id",    32'(rsp_id),    32'h0);
    chk("reset_rsp_data",  32'(rsp_data),  32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 4'b0000;

    for (int v = 0; v < 17; v++) begin
      en = tbl[v].en; req_valid = tbl[v].vld; rsp_ready = tbl[v].rdy;
      #4;
      chk($sformatf("v%0d_req_ready", v), 32'(req_ready), 32'(tbl[v].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'(tbl[v].exp_valid));
      chk($sformatf("v%0d_rsp_id", v),    32'(rsp_id),    32'(tbl[v].exp_id));
      chk($sformatf("v%0d_rsp_data", v),  32'(rsp_data),  32'(tbl[v].exp_data));
    end

    // Reset while a product is held under backpressure.
    en = 1'b1; req_valid = 4'b0100; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    chk("pre_reset_valid", 32'(rsp_valid), 32'h1);
    #2 rst_n = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'h0);
    chk("async_rst_id",    32'(rsp_id),    32'h0);
    chk("async_rst_data",  32'(rsp_data),  32'h0);
    chk("async_rst_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    #3;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_id",    32'(rsp_id),    32'h0);

    // Full-rate round robin with every requester asking.
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      automatic logic [1:0] eid = 2'((c + 1) % 4);
      #3;
      chk($sformatf("rr%0d_ready", c), 32'(req_ready), 32'(4'b0001 << eid));
      @(posedge clk); #1;
      chk($sformatf("rr%0d_valid", c), 32'(rsp_valid), 32'h1);
      chk($sformatf("rr%0d_id", c),    32'(rsp_id),    32'(eid));
      chk($sformatf("rr%0d_data", c),  32'(rsp_data),  32'(prod[eid]));
    end
    req_valid = 4'b0000; rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Random operands, valid, enable and backpressure against a scoreboard.
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    n_xfer = 0;
    for (int c = 0; c < 2001; c++) begin
      en        = (c == 2000) ? 1'b0 : ($urandom_range(0, 3) != 0);
      rsp_ready = (c == 2000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1 && c < 2000) begin
          pend[i] = 1'b1;
          ra[i] = 8'($urandom);
          rb[i] = 8'($urandom);
        end
        req_valid[i] = pend[i];
        req_op1[i*8 +: 8] = ra[i];
        req_op2[i*8 +: 8] = rb[i];
      end
      #4;
      chk("rand_ready_onehot",
          32'(($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == 4'b0000)), 32'h1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious_rsp", 32'(rsp_valid), 32'h0);
        end else begin
          chk("rand_rsp", {14'h0, rsp_id, rsp_data}, {14'h0, exp_q[0].id, exp_q[0].data});
          void'(exp_q.pop_front());
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          exp_q.push_back('{id: 2'(i), data: {8'h00, ra[i]} * {8'h00, rb[i]}});
          pend[i] = 1'b0;
          n_xfer++;
        end
      end
      @(posedge clk); #1;
    end
    #4;
    chk("rand_drain_valid", 32'(rsp_valid), 32'h0);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'h0);
    chk("rand_some_xfers",  32'(n_xfer > 500), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
